// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: ID-to-EX bundle for ex_operand_stage.
// Carries the decoded ID fields in, and the ALU operands, EX controls and load-use flag out.
interface ex_operand_stage_if;
   logic        id_valid;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [1:0]  id_alu_op;
   logic [5:0]  id_funct;
   logic        id_alu_src;
   logic        id_reg_dst;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        id_mem_to_reg;

   logic [31:0] data1;
   logic [31:0] data2;
   logic [3:0]  ALU_control;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_write_reg;
   logic        ex_valid;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_mem_to_reg;
   logic        load_use_stall;

   modport master (
      output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
             id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
             id_mem_read, id_mem_write, id_mem_to_reg,
      input  data1, data2, ALU_control, ex_store_data, ex_write_reg, ex_valid,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall
   );

   modport slave (
      input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
             id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
             id_mem_read, id_mem_write, id_mem_to_reg,
      output data1, data2, ALU_control, ex_store_data, ex_write_reg, ex_valid,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall
   );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register, ALU-control decode, operand forwarding and load-use detection.
// Define FORWARDING_EN for EX/MEM and MEM/WB forwarding; without it any EX write dependency stalls.
module ex_operand_stage (
   input  logic              clk,
   input  logic              rst,
   ex_operand_stage_if.slave bus,
   input  logic              hold,
   input  logic              flush,
   input  logic              exmem_reg_write,
   input  logic [4:0]        exmem_rd,
   input  logic [31:0]       exmem_result,
   input  logic              memwb_reg_write,
   input  logic [4:0]        memwb_rd,
   input  logic [31:0]       memwb_result
);

   typedef struct packed {
      logic        valid;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  write_reg;
      logic [3:0]  alu_ctrl;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
   } stage_t;

   stage_t      stage_q;
   stage_t      stage_d;
   logic [3:0]  alu_ctrl_dec;
   logic [31:0] fwd_a;
   logic [31:0] fwd_b;
   logic        hazard_match;
   logic        load_use;

   always_comb begin
      alu_ctrl_dec = 4'b1111;
      case (bus.id_alu_op)
         2'b00: alu_ctrl_dec = 4'b0010;
         2'b01: alu_ctrl_dec = 4'b0110;
         2'b11: alu_ctrl_dec = 4'b0001;
         default: begin
            case (bus.id_funct)
               6'b100000: alu_ctrl_dec = 4'b0010;
               6'b100010: alu_ctrl_dec = 4'b0110;
               6'b100100: alu_ctrl_dec = 4'b0000;
               6'b100101: alu_ctrl_dec = 4'b0001;
               6'b101010: alu_ctrl_dec = 4'b0111;
               6'b100111: alu_ctrl_dec = 4'b1100;
               default:   alu_ctrl_dec = 4'b1111;
            endcase
         end
      endcase
   end

   assign hazard_match = bus.id_valid && stage_q.valid && (stage_q.write_reg != 5'd0) &&
                         ((stage_q.write_reg == bus.id_rs) || (stage_q.write_reg == bus.id_rt));

`ifdef FORWARDING_EN
   assign load_use = hazard_match && stage_q.mem_read;

   // EX/MEM is the younger result, so it wins over MEM/WB; register 0 never forwards.
   always_comb begin
      fwd_a = stage_q.rs_data;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == stage_q.rs))
         fwd_a = exmem_result;
      else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == stage_q.rs))
         fwd_a = memwb_result;

      fwd_b = stage_q.rt_data;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == stage_q.rt))
         fwd_b = exmem_result;
      else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == stage_q.rt))
         fwd_b = memwb_result;
   end
`else
   logic unused_fwd;

   assign load_use   = hazard_match && stage_q.reg_write;
   assign fwd_a      = stage_q.rs_data;
   assign fwd_b      = stage_q.rt_data;
   assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_result,
                         stage_q.rs, stage_q.rt};
`endif

   // A non-valid ID slot still moves through, but can never write or touch memory.
   always_comb begin
      stage_d = stage_q;
      if (!hold) begin
         if (flush || load_use) begin
            stage_d = '0;
         end else begin
            stage_d.valid      = bus.id_valid;
            stage_d.rs_data    = bus.id_rs_data;
            stage_d.rt_data    = bus.id_rt_data;
            stage_d.imm        = bus.id_imm;
            stage_d.rs         = bus.id_rs;
            stage_d.rt         = bus.id_rt;
            stage_d.write_reg  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            stage_d.alu_ctrl   = alu_ctrl_dec;
            stage_d.alu_src    = bus.id_alu_src;
            stage_d.reg_write  = bus.id_valid && bus.id_reg_write;
            stage_d.mem_read   = bus.id_valid && bus.id_mem_read;
            stage_d.mem_write  = bus.id_valid && bus.id_mem_write;
            stage_d.mem_to_reg = bus.id_valid && bus.id_mem_to_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stage_q <= '0;
      else
         stage_q <= stage_d;
   end

   assign bus.data1          = fwd_a;
   assign bus.data2          = stage_q.alu_src ? stage_q.imm : fwd_b;
   assign bus.ex_store_data  = fwd_b;
   assign bus.ALU_control    = stage_q.alu_ctrl;
   assign bus.ex_write_reg   = stage_q.write_reg;
   assign bus.ex_valid       = stage_q.valid;
   assign bus.ex_reg_write   = stage_q.reg_write;
   assign bus.ex_mem_read    = stage_q.mem_read;
   assign bus.ex_mem_write   = stage_q.mem_write;
   assign bus.ex_mem_to_reg  = stage_q.mem_to_reg;
   assign bus.load_use_stall = load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed and randomized checks of ex_operand_stage against an
// instruction-level model of the ID/EX slot; honours FORWARDING_EN the same way the design does.
module tb_ex_operand_stage;

   typedef struct {
      logic        rst, hold, flush;
      logic        id_valid;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd;
      logic [1:0]  alu_op;
      logic [5:0]  funct;
      logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
      logic        ex_rw;
      logic [4:0]  ex_rd;
      logic [31:0] ex_res;
      logic        wb_rw;
      logic [4:0]  wb_rd;
      logic [31:0] wb_res;
   } stim_t;

   // The instruction currently sitting in EX, as the model sees it.
   typedef struct {
      logic        valid;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  rs, rt, dest;
      logic [3:0]  op_code;
      logic        use_imm, writes, loads, stores, to_reg;
   } slot_t;

   logic clk;
   logic rst;
   logic hold;
   logic flush;
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_result;

   ex_operand_stage_if bus();

   ex_operand_stage dut (
      .clk             (clk),
      .rst             (rst),
      .bus             (bus),
      .hold            (hold),
      .flush           (flush),
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result)
   );

   int          vec_count = 0;
   int          miss_count = 0;
   stim_t       cur;
   stim_t       idle;
   slot_t       m;
   slot_t       empty_slot;
   logic [3:0]  funct_map [logic [5:0]];
   logic [5:0]  known_functs [6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vec_count++;
      if (actual !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   function automatic logic [3:0] aluCode(input logic [1:0] op, input logic [5:0] funct);
      if (op == 2'b00) return 4'b0010;
      if (op == 2'b01) return 4'b0110;
      if (op == 2'b11) return 4'b0001;
      if (funct_map.exists(funct)) return funct_map[funct];
      return 4'b1111;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] held);
`ifdef FORWARDING_EN
      if (r != 0 && cur.ex_rw && cur.ex_rd == r) return cur.ex_res;
      if (r != 0 && cur.wb_rw && cur.wb_rd == r) return cur.wb_res;
`endif
      return held;
   endfunction

   function automatic logic expStall();
      logic dep;
      dep = m.valid && cur.id_valid && m.dest != 0 && (m.dest == cur.rs || m.dest == cur.rt);
`ifdef FORWARDING_EN
      return dep && m.loads;
`else
      return dep && m.writes;
`endif
   endfunction

   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      cur                = s;
      rst                = s.rst;
      hold               = s.hold;
      flush              = s.flush;
      bus.id_valid       = s.id_valid;
      bus.id_rs_data     = s.rs_data;
      bus.id_rt_data     = s.rt_data;
      bus.id_imm         = s.imm;
      bus.id_rs          = s.rs;
      bus.id_rt          = s.rt;
      bus.id_rd          = s.rd;
      bus.id_alu_op      = s.alu_op;
      bus.id_funct       = s.funct;
      bus.id_alu_src     = s.alu_src;
      bus.id_reg_dst     = s.reg_dst;
      bus.id_reg_write   = s.reg_write;
      bus.id_mem_read    = s.mem_read;
      bus.id_mem_write   = s.mem_write;
      bus.id_mem_to_reg  = s.mem_to_reg;
      exmem_reg_write    = s.ex_rw;
      exmem_rd           = s.ex_rd;
      exmem_result       = s.ex_res;
      memwb_reg_write    = s.wb_rw;
      memwb_rd           = s.wb_rd;
      memwb_result       = s.wb_res;
      #1;
   endtask

   task automatic checkModel();
      logic [31:0] b_val;
      b_val = operand(m.rt, m.rt_data);
      checkOutput("data1",      bus.data1, operand(m.rs, m.rs_data));
      checkOutput("data2",      bus.data2, m.use_imm ? m.imm : b_val);
      checkOutput("store_data", bus.ex_store_data, b_val);
      checkOutput("alu_ctrl",   32'(bus.ALU_control), 32'(m.op_code));
      checkOutput("write_reg",  32'(bus.ex_write_reg), 32'(m.dest));
      checkOutput("ex_valid",   32'(bus.ex_valid), 32'(m.valid));
      checkOutput("reg_write",  32'(bus.ex_reg_write), 32'(m.writes));
      checkOutput("mem_read",   32'(bus.ex_mem_read), 32'(m.loads));
      checkOutput("mem_write",  32'(bus.ex_mem_write), 32'(m.stores));
      checkOutput("mem_to_reg", 32'(bus.ex_mem_to_reg), 32'(m.to_reg));
      checkOutput("stall",      32'(bus.load_use_stall), 32'(expStall()));
   endtask

   // Move the model's EX slot across one clock edge using the inputs presented this cycle.
   task automatic advance();
      logic stall;
      stall = expStall();
      @(posedge clk);
      if (cur.rst) m = empty_slot;
      else if (cur.hold) m = m;
      else if (cur.flush || stall) m = empty_slot;
      else begin
         m.valid   = cur.id_valid;
         m.rs_data = cur.rs_data;
         m.rt_data = cur.rt_data;
         m.imm     = cur.imm;
         m.rs      = cur.rs;
         m.rt      = cur.rt;
         m.dest    = cur.reg_dst ? cur.rd : cur.rt;
         m.op_code = aluCode(cur.alu_op, cur.funct);
         m.use_imm = cur.alu_src;
         m.writes  = cur.id_valid & cur.reg_write;
         m.loads   = cur.id_valid & cur.mem_read;
         m.stores  = cur.id_valid & cur.mem_write;
         m.to_reg  = cur.id_valid & cur.mem_to_reg;
      end
   endtask

   task automatic step(input stim_t s);
      applyStimulus(s);
      checkModel();
      advance();
   endtask

   function automatic stim_t randStim();
      stim_t s;
      s.rst        = ($urandom_range(0, 49) == 0);
      s.hold       = ($urandom_range(0, 9) == 0);
      s.flush      = ($urandom_range(0, 9) == 0);
      s.id_valid   = ($urandom_range(0, 4) != 0);
      s.rs_data    = $urandom;
      s.rt_data    = $urandom;
      s.imm        = $urandom;
      s.rs         = 5'($urandom_range(0, 7));
      s.rt         = 5'($urandom_range(0, 7));
      s.rd         = 5'($urandom_range(0, 7));
      s.alu_op     = 2'($urandom_range(0, 3));
      s.funct      = ($urandom_range(0, 3) != 0) ? known_functs[$urandom_range(0, 5)] : 6'($urandom);
      s.alu_src    = 1'($urandom);
      s.reg_dst    = 1'($urandom);
      s.reg_write  = 1'($urandom);
      s.mem_read   = 1'($urandom);
      s.mem_write  = 1'($urandom);
      s.mem_to_reg = 1'($urandom);
      s.ex_rw      = 1'($urandom);
      s.ex_rd      = 5'($urandom_range(0, 7));
      s.ex_res     = $urandom;
      s.wb_rw      = 1'($urandom);
      s.wb_rd      = 5'($urandom_range(0, 7));
      s.wb_res     = $urandom;
      return s;
   endfunction

   // Directed scenarios first, then a long randomized run checked cycle by cycle.
   initial begin
      stim_t s;
      funct_map[6'b100000] = 4'b0010;
      funct_map[6'b100010] = 4'b0110;
      funct_map[6'b100100] = 4'b0000;
      funct_map[6'b100101] = 4'b0001;
      funct_map[6'b101010] = 4'b0111;
      funct_map[6'b100111] = 4'b1100;
      known_functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
      idle       = '{default: '0};
      empty_slot = '{default: '0};
      m          = empty_slot;

      s = idle; s.rst = 1'b1;
      applyStimulus(s); advance();
      applyStimulus(s); advance();
      applyStimulus(idle); checkModel();
      checkOutput("reset_valid", 32'(bus.ex_valid), 32'd0);
      checkOutput("reset_alu",   32'(bus.ALU_control), 32'd0);
      checkOutput("reset_data1", bus.data1, 32'd0);
      advance();

      s = idle; s.id_valid = 1; s.alu_op = 2'b10; s.funct = 6'b101010;
      s.rs = 1; s.rt = 2; s.rd = 7; s.rs_data = 5; s.rt_data = 9; s.reg_dst = 1; s.reg_write = 1;
      step(s);
      applyStimulus(idle); checkModel();
      checkOutput("rtype_data1", bus.data1, 32'd5);
      checkOutput("rtype_data2", bus.data2, 32'd9);
      checkOutput("rtype_alu",   32'(bus.ALU_control), 32'b0111);
      checkOutput("rtype_wreg",  32'(bus.ex_write_reg), 32'd7);
      advance();

      s = idle; s.id_valid = 1; s.alu_op = 2'b00; s.alu_src = 1; s.imm = 32'hFFFF_FFFC;
      s.rs = 3; s.rt = 9; s.rd = 12; s.reg_write = 1;
      step(s);
      applyStimulus(idle); checkModel();
      checkOutput("itype_data2", bus.data2, 32'hFFFF_FFFC);
      checkOutput("itype_alu",   32'(bus.ALU_control), 32'b0010);
      checkOutput("itype_wreg",  32'(bus.ex_write_reg), 32'd9);
      advance();

      s = idle; s.id_valid = 1; s.alu_op = 2'b10; s.funct = 6'b100000;
      s.rs = 3; s.rt = 2; s.rd = 10; s.reg_dst = 1; s.reg_write = 1;
      s.rs_data = 32'h1111; s.rt_data = 32'h2222;
      step(s);
      s = idle; s.hold = 1; s.ex_rw = 1; s.ex_rd = 3; s.ex_res = 32'hAAAA;
      s.wb_rw = 1; s.wb_rd = 3; s.wb_res = 32'hBBBB;
      applyStimulus(s); checkModel();
`ifdef FORWARDING_EN
      checkOutput("fwd_exmem", bus.data1, 32'hAAAA);
`else
      checkOutput("fwd_exmem", bus.data1, 32'h1111);
`endif
      advance();
      s.ex_rw = 0;
      applyStimulus(s); checkModel();
`ifdef FORWARDING_EN
      checkOutput("fwd_memwb", bus.data1, 32'hBBBB);
`else
      checkOutput("fwd_memwb", bus.data1, 32'h1111);
`endif
      advance();
      s.ex_rw = 1; s.ex_rd = 0; s.wb_rd = 0;
      applyStimulus(s); checkModel();
      checkOutput("fwd_r0", bus.data1, 32'h1111);
      advance();

      s = idle; s.id_valid = 1; s.alu_op = 2'b00; s.alu_src = 1; s.rs = 1; s.rt = 4;
      s.mem_read = 1; s.reg_write = 1; s.mem_to_reg = 1; s.imm = 32'd8;
      step(s);
      s = idle; s.id_valid = 1; s.alu_op = 2'b10; s.funct = 6'b100000;
      s.rs = 4; s.rt = 5; s.rd = 6; s.reg_dst = 1; s.reg_write = 1;
      applyStimulus(s); checkModel();
      checkOutput("lu_stall", 32'(bus.load_use_stall), 32'd1);
      advance();
      applyStimulus(s); checkModel();
      checkOutput("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
      checkOutput("lu_bubble_rw",    32'(bus.ex_reg_write), 32'd0);
      checkOutput("lu_stall_clear",  32'(bus.load_use_stall), 32'd0);
      advance();

      s = idle; s.hold = 1; s.flush = 1; s.id_valid = 1; s.rd = 20; s.reg_dst = 1;
      applyStimulus(s); checkModel();
      checkOutput("lu_captured", 32'(bus.ex_write_reg), 32'd6);
      advance();
      s = idle; s.flush = 1;
      applyStimulus(s); checkModel();
      checkOutput("hold_kept_valid", 32'(bus.ex_valid), 32'd1);
      checkOutput("hold_kept_wreg",  32'(bus.ex_write_reg), 32'd6);
      advance();
      applyStimulus(idle); checkModel();
      checkOutput("flush_bubble", 32'(bus.ex_valid), 32'd0);
      advance();

      s = idle; s.id_valid = 1; s.alu_op = 2'b11; s.rt = 3; s.reg_write = 1;
      step(s);
      s.rst = 1;
      step(s);
      applyStimulus(idle); checkModel();
      checkOutput("midrst_valid", 32'(bus.ex_valid), 32'd0);
      checkOutput("midrst_alu",   32'(bus.ALU_control), 32'd0);
      advance();

      for (int i = 0; i < 600; i++) step(randStim());

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-selection stage of the pipelined MIPS core, sitting directly upstream of the ALU. Each cycle it captures decoded instruction fields and register-file read data from ID. It decodes ALUOp/funct into the 4-bit ALU control code and drives the ALU's `data1`, `data2` and `ALU_control` inputs, resolving RAW hazards by forwarding. It also flags load-use hazards back to the ID stage and carries the write-back and memory controls forward to EX/MEM.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `id_valid` in 1: ID slot holds a real instruction.
- `id_rs_data`, `id_rt_data` in 32: register-file read data.
- `id_imm` in 32: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd` in 5: register numbers.
- `id_alu_op` in 2: main-decoder ALUOp.
- `id_funct` in 6: instruction funct field.
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1: decoder controls.
- `hold` in 1: downstream stall; freeze all state.
- `flush` in 1: branch/jump squash; load a bubble.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forwarding source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in 32: MEM/WB forwarding source.
- `data1` out 32: ALU operand 1.
- `data2` out 32: ALU operand 2.
- `ALU_control` out 4: ALU operation code.
- `ex_store_data` out 32: forwarded rt value, used as store data.
- `ex_write_reg` out 5: destination register.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1: registered controls.
- `load_use_stall` out 1: combinational; ID must hold and this stage inserts a bubble.

## Operation
- Registered state: valid, rs_data, rt_data, imm, rs, rt, write_reg, alu_ctrl, alu_src, and the four memory/write-back controls.
- `ex_write_reg` is captured as `id_reg_dst ? id_rd : id_rt`.
- ALU control decode, registered with the rest of the state:
  - ALUOp 00 → 0010 (add).
  - ALUOp 01 → 0110 (sub).
  - ALUOp 11 → 0001 (or).
  - ALUOp 10 decodes funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111→1100. Any other funct → 1111, which the ALU treats as result 0.
- Load-use hazard: `load_use_stall = ex_valid & ex_mem_read & (ex_write_reg != 0) & id_valid & (ex_write_reg == id_rs | ex_write_reg == id_rt)`.
- Update priority per edge:
  1. `rst`: all state is zeroed.
  2. `hold`: state is unchanged.
  3. `flush` or `load_use_stall`: a bubble is loaded (valid and all control bits 0, alu_ctrl 0000, data fields 0).
  4. Otherwise the ID fields are captured. An instruction with `id_valid=0` is captured with all write and memory controls forced to 0.
- Forwarding per operand (rs → fwd_a, rt → fwd_b):
  - EX/MEM is used when `exmem_reg_write`, `exmem_rd != 0` and `exmem_rd` matches the register.
  - Otherwise MEM/WB is used under the same conditions.
  - Otherwise the registered data is used.
  - EX/MEM has priority when both sources match.
  - Register 0 is never forwarded.
- `data1 = fwd_a`.
- `data2 = alu_src ? imm : fwd_b`.
- `ex_store_data = fwd_b`.
- `ALU_control` is driven from the registered alu_ctrl.

## Timing
- Latency: one cycle from ID capture to valid ALU operands.
- Operand outputs are combinational from registered state plus the same-cycle forwarding inputs.
- Reset values: every registered output is 0. `ALU_control` is 0000, and `data1`/`data2`/`ex_store_data` are 0 unless forwarding inputs match register 0, which never occurs.
- `load_use_stall` is asserted in the same cycle as the dependent instruction in ID. It deasserts the next cycle once the bubble occupies the stage.
- `hold` overrides `flush` and `load_use_stall`; the squash or bubble is applied on the first cycle after `hold` drops.
- `rst` asserted mid-stream discards the in-flight instruction on that edge.

## Configuration
- `FORWARDING_EN` defined: forwarding muxes as described.
- `FORWARDING_EN` undefined:
  - `fwd_a`/`fwd_b` are the registered rs_data/rt_data.
  - The exmem/memwb inputs are ignored.
  - `load_use_stall` widens to any `ex_valid & ex_reg_write & (ex_write_reg != 0)` match against `id_rs` or `id_rt`; the software/hazard unit handles the remaining distances.

## Test plan
- Reset with `rst=1` for 2 cycles → all outputs 0, `ex_valid=0`, `ALU_control=0000`.
- R-type capture: ALUOp=10, funct=101010, rs_data=5, rt_data=9, alu_src=0 → next cycle `data1=5`, `data2=9`, `ALU_control=0111`, `ex_write_reg=id_rd`.
- Forward priority: registered rs=3; exmem_rd=3 with 0xAAAA; memwb_rd=3 with 0xBBBB; both regwrite=1 → `data1=0xAAAA`. Drop exmem_reg_write → `data1=0xBBBB`. Set rd=0 on both → registered data.
- Load-use: EX holds lw with rt=4; ID has rs=4, id_valid=1 → `load_use_stall=1`. Next cycle `ex_valid=0` and all controls 0; the following cycle the held instruction captures.
- Hold vs flush: `hold=1` and `flush=1` together → state unchanged. After `hold=0` with `flush=1` → bubble loaded.
- I-type: ALUOp=00, alu_src=1, imm=0xFFFFFFFC, reg_dst=0 → `data2=0xFFFFFFFC`, `ALU_control=0010`, `ex_write_reg=id_rt`.
